// File: rtl/l2arb_pkg.sv
// Shared types and constants for the L2 read-port arbiter.
package l2arb_pkg;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

   localparam int NREQ  = 3;
   localparam int REQ_W = 0;
   localparam int REQ_I = 1;
   localparam int REQ_O = 2;

   // Width able to hold 0..depth (credit, outstanding and occupancy counts)
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Requester, L2 and response channels of the arbiter bundled as one interface.
interface l2_port_arbiter_if
   import l2arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
);
   logic [NREQ-1:0]        req_vld;
   logic [NREQ-1:0]        req_rdy;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*LEN_W-1:0]  req_len;
   logic                   mem_req_vld;
   logic                   mem_req_rdy;
   logic [ADDR_W-1:0]      mem_req_addr;
   logic                   mem_rsp_vld;
   logic [DATA_W-1:0]      mem_rsp_dat;
   logic [NREQ-1:0]        rsp_vld;
   logic [NREQ-1:0]        rsp_rdy;
   logic [DATA_W-1:0]      rsp_dat;
   logic                   busy;
   logic [1:0]             owner;

   modport slave (
      input  req_vld, req_addr, req_len, mem_req_rdy, mem_rsp_vld, mem_rsp_dat, rsp_rdy,
      output req_rdy, mem_req_vld, mem_req_addr, rsp_vld, rsp_dat, busy, owner
   );

   modport master (
      output req_vld, req_addr, req_len, mem_req_rdy, mem_rsp_vld, mem_rsp_dat, rsp_rdy,
      input  req_rdy, mem_req_vld, mem_req_addr, rsp_vld, rsp_dat, busy, owner
   );
endinterface

// File: rtl/l2arb_rsp_fifo.sv
// Response buffer: DEPTH x DATA_W FIFO, write-to-read latency 1, storage reset to 0.
// No internal backpressure: the caller only pushes when not full or popping in the same cycle.
module l2arb_rsp_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_dat_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_dat_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  occ_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  occ_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
         occ_q <= occ_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign full_o     = (occ_q == CNT_W'(DEPTH));
   assign empty_o    = (occ_q == '0);
   assign occ_o      = occ_q;
endmodule

// File: rtl/l2_port_arbiter.sv
// Grants one W/I/O refill burst at a time onto the L2 read port (round-robin, or fixed W>I>O with
// L2ARB_FIXED_PRIO_EN); accept in 1 cycle, reads issue under DEPTH credits, responses +1 cycle via buffer.
module l2_port_arbiter
   import l2arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4,
   parameter int DEPTH  = 2
) (
   input logic              clk,
   input logic              rst,
   l2_port_arbiter_if.slave bus
);
   localparam int CRD_W = credit_w(DEPTH);

   state_e             state_q;
   logic [1:0]         owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   cnt_q;
   logic [CRD_W-1:0]   credit_q, credit_d;
   logic [CRD_W-1:0]   outst_q, outst_d;
`ifndef L2ARB_FIXED_PRIO_EN
   logic [1:0]         ptr_q;
`endif

   logic [1:0]         win;
   logic               win_vld;
   logic               accept, pop, issue_vld, issue, rsp_wr, drain_done;
   logic               full, empty;
   logic [CRD_W-1:0]   occ;
   logic [DATA_W-1:0]  head_dat;

   // Lowest search position is visited last so it overrides later candidates
   always_comb begin
      logic [1:0] j;
      win     = '0;
      win_vld = 1'b0;
      j       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef L2ARB_FIXED_PRIO_EN
         j = 2'(k);
`else
         j = 2'((int'(ptr_q) + k) % NREQ);
`endif
         if (bus.req_vld[j]) begin
            win     = j;
            win_vld = 1'b1;
         end
      end
   end

   assign accept     = (state_q == IDLE) && win_vld && !rst;
   assign pop        = !empty && bus.rsp_rdy[owner_q];
   assign issue_vld  = (state_q == BURST) && ((credit_q != '0) || pop);
   assign issue      = issue_vld && bus.mem_req_rdy;
   assign rsp_wr     = bus.mem_rsp_vld && (outst_q != '0);
   assign drain_done = (outst_q == '0) && (empty || ((occ == CRD_W'(1)) && pop));
   assign credit_d   = credit_q - CRD_W'(issue) + CRD_W'(pop);
   assign outst_d    = outst_q + CRD_W'(issue) - CRD_W'(rsp_wr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         addr_q   <= '0;
         cnt_q    <= '0;
         credit_q <= CRD_W'(DEPTH);
         outst_q  <= '0;
`ifndef L2ARB_FIXED_PRIO_EN
         ptr_q    <= '0;
`endif
      end else begin
         credit_q <= credit_d;
         outst_q  <= outst_d;
         case (state_q)
            IDLE: if (accept) begin
               addr_q  <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
               cnt_q   <= bus.req_len[int'(win)*LEN_W +: LEN_W];
               owner_q <= win;
`ifndef L2ARB_FIXED_PRIO_EN
               ptr_q   <= (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
`endif
               state_q <= BURST;
            end
            BURST: if (issue) begin
               addr_q <= addr_q + 1'b1;
               cnt_q  <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= DRAIN;
            end
            DRAIN: if (drain_done) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   l2arb_rsp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (rsp_wr),
      .push_dat_i (bus.mem_rsp_dat),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .full_o     (full),
      .empty_o    (empty),
      .occ_o      (occ)
   );

   assign bus.req_rdy      = accept ? (NREQ'(1) << win) : '0;
   assign bus.mem_req_vld  = issue_vld;
   assign bus.mem_req_addr = addr_q;
   assign bus.rsp_vld      = empty ? '0 : (NREQ'(1) << owner_q);
   assign bus.rsp_dat      = head_dat;
   assign bus.busy         = (state_q != IDLE);
   assign bus.owner        = owner_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(bus.mem_rsp_vld && full && !pop));
   a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
      !(bus.mem_rsp_vld && (outst_q == '0)));
endmodule
